// File: rtl/sa_inst_sequencer.sv
// sa_inst_sequencer: replays a descriptor program as a systolic-array instruction
// stream, paced by the array's flag / idle_flag handshake.
// Optional build macro SA_SEQ_STEP_EN adds step_mode/step single-step control.
//
// State table
//   state      | meaning
//   S_IDLE     | not running, waiting for start
//   S_LOAD     | read descriptor at pc, set up first address pair
//   S_ISSUE    | instruction driven, waiting for flag==1 (taken)
//   S_WAIT_LO  | instruction held, waiting for flag==0 (step done)
//   S_SYNC     | first instruction of a sync descriptor done, wait idle_flag==0
//   S_STEP     | advance repeat index and addresses
//   S_GAP      | idle instruction held for one full flag 1->0 cycle
//   S_END      | run finished, pulse done
module sa_inst_sequencer #(
  parameter int OPCODE_BITS = 4,
  parameter int ADDR_BITS   = 8,
  parameter int CNT_BITS    = 9,
  parameter int PROG_DEPTH  = 16,
  parameter logic [OPCODE_BITS-1:0] IDLE_OPCODE = '0,
  localparam int INST_BITS  = OPCODE_BITS + 2*ADDR_BITS,
  localparam int DESC_BITS  = 1 + OPCODE_BITS + 4*ADDR_BITS + CNT_BITS,
  localparam int PC_BITS    = $clog2(PROG_DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 prog_we,
  input  logic [PC_BITS-1:0]   prog_addr,
  input  logic [DESC_BITS-1:0] prog_wdata,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 flag,
  input  logic                 idle_flag,
`ifdef SA_SEQ_STEP_EN
  input  logic                 step_mode,
  input  logic                 step,
`endif
  output logic [INST_BITS-1:0] instruction,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          issued_cnt
);

  localparam logic [INST_BITS-1:0] IDLE_INST = {IDLE_OPCODE, {(2*ADDR_BITS){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_WAIT_LO, S_SYNC, S_STEP, S_GAP, S_END
  } state_t;

  state_t                 state;
  logic [DESC_BITS-1:0]   prog_ram [PROG_DEPTH];
  logic [PC_BITS-1:0]     pc;
  logic [CNT_BITS-1:0]    i_cnt;
  logic [ADDR_BITS-1:0]   a_addr;
  logic [ADDR_BITS-1:0]   b_addr;
  logic                   gap_hi;

  // The RAM is frozen while busy, so the current descriptor is read in place.
  logic [DESC_BITS-1:0]   desc;
  logic                   d_sync;
  logic [OPCODE_BITS-1:0] d_op;
  logic [ADDR_BITS-1:0]   d_a_base, d_b_base, d_a_stride, d_b_stride;
  logic [CNT_BITS-1:0]    d_count;
  logic [CNT_BITS-1:0]    i_next;
  logic [ADDR_BITS-1:0]   a_next, b_next;
  logic                   adv_ok;

  assign desc       = prog_ram[pc];
  assign d_sync     = desc[DESC_BITS-1];
  assign d_op       = desc[DESC_BITS-2 -: OPCODE_BITS];
  assign d_a_base   = desc[CNT_BITS+4*ADDR_BITS-1 -: ADDR_BITS];
  assign d_b_base   = desc[CNT_BITS+3*ADDR_BITS-1 -: ADDR_BITS];
  assign d_a_stride = desc[CNT_BITS+2*ADDR_BITS-1 -: ADDR_BITS];
  assign d_b_stride = desc[CNT_BITS+ADDR_BITS-1 -: ADDR_BITS];
  assign d_count    = desc[CNT_BITS-1:0];

  assign i_next = i_cnt + 1'b1;
  assign a_next = a_addr + d_a_stride;
  assign b_next = b_addr + d_b_stride;

`ifdef SA_SEQ_STEP_EN
  assign adv_ok = !step_mode || step;
`else
  assign adv_ok = 1'b1;
`endif

  // Descriptor RAM: writes only while no run is in progress; not cleared by reset.
  always_ff @(posedge clk) begin
    if (prog_we && !busy) begin
      prog_ram[prog_addr] <= prog_wdata;
    end
  end

  // Sequencer FSM with registered instruction/busy/done/issued_cnt.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      instruction <= IDLE_INST;
      busy        <= 1'b0;
      done        <= 1'b0;
      issued_cnt  <= '0;
      pc          <= '0;
      i_cnt       <= '0;
      a_addr      <= '0;
      b_addr      <= '0;
      gap_hi      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state       <= S_IDLE;
        instruction <= IDLE_INST;
        busy        <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              pc         <= '0;
              issued_cnt <= '0;
              busy       <= 1'b1;
              state      <= S_LOAD;
            end
          end
          S_LOAD: begin
            if (adv_ok) begin
              if (d_count == '0) begin
                state <= S_END;
              end else begin
                i_cnt       <= '0;
                a_addr      <= d_a_base;
                b_addr      <= d_b_base;
                instruction <= {d_op, d_a_base, d_b_base};
                state       <= S_ISSUE;
              end
            end
          end
          S_ISSUE: begin
            if (flag) state <= S_WAIT_LO;
          end
          S_WAIT_LO: begin
            if (!flag) begin
              issued_cnt <= issued_cnt + 16'd1;
              state      <= (d_sync && i_cnt == '0) ? S_SYNC : S_STEP;
            end
          end
          S_SYNC: begin
            if (!idle_flag) state <= S_STEP;
          end
          S_STEP: begin
            if (adv_ok) begin
              i_cnt <= i_next;
              if (i_next == d_count) begin
                instruction <= IDLE_INST;
                gap_hi      <= 1'b0;
                state       <= S_GAP;
              end else begin
                a_addr      <= a_next;
                b_addr      <= b_next;
                instruction <= {d_op, a_next, b_next};
                state       <= S_ISSUE;
              end
            end
          end
          S_GAP: begin
            // The idle instruction must see a complete flag high-then-low cycle.
            if (!gap_hi) begin
              if (flag) gap_hi <= 1'b1;
            end else if (!flag) begin
              pc    <= pc + 1'b1;
              state <= (pc == PC_BITS'(PROG_DEPTH-1)) ? S_END : S_LOAD;
            end
          end
          S_END: begin
            instruction <= IDLE_INST;
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= S_IDLE;
          end
          default: begin
            instruction <= IDLE_INST;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sa_inst_sequencer.sv
// Testbench for sa_inst_sequencer: randomized descriptor programs checked against
// a list-of-instructions reference model derived from the descriptor rules.
module tb_sa_inst_sequencer;

  localparam int DESC_W = 46;
  localparam int INST_W = 20;
  localparam logic [INST_W-1:0] IDLE_I = '0;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              prog_we;
  logic [3:0]        prog_addr;
  logic [DESC_W-1:0] prog_wdata;
  logic              start, abort, flag, idle_flag;
`ifdef SA_SEQ_STEP_EN
  logic              step_mode, step;
`endif
  logic [INST_W-1:0] instruction;
  logic              busy, done;
  logic [15:0]       issued_cnt;

  int total = 0;
  int bad = 0;

  logic [DESC_W-1:0] prog_m [16];
  logic [INST_W-1:0] exp_q[$];
  logic [INST_W-1:0] got_q[$];
  int                done_cnt = 0;
  logic [15:0]       prev_cnt = '0;
  bit                flag_rand = 0;

  sa_inst_sequencer dut (
    .clk(clk), .reset_n(reset_n), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .start(start), .abort(abort), .flag(flag),
    .idle_flag(idle_flag),
`ifdef SA_SEQ_STEP_EN
    .step_mode(step_mode), .step(step),
`endif
    .instruction(instruction), .busy(busy), .done(done), .issued_cnt(issued_cnt)
  );

  always #5 clk = ~clk;

  // Array model: flag toggles every 2 cycles, or with random 1..3 cycle holds.
  initial begin
    flag = 1'b0;
    forever begin
      repeat (flag_rand ? int'($urandom_range(1, 3)) : 2) @(posedge clk);
      #2 flag = ~flag;
    end
  end

  // Observer: logs each completed instruction (held while issued_cnt steps) and done pulses.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (done === 1'b1) done_cnt++;
      if (issued_cnt === prev_cnt + 16'd1) got_q.push_back(instruction);
      prev_cnt = issued_cnt;
    end
  end

  function automatic logic [DESC_W-1:0] mk_desc(input bit sync, input int op, input int ab,
      input int bb, input int as, input int bs, input int cnt);
    return {sync, 4'(op), 8'(ab), 8'(bb), 8'(as), 8'(bs), 9'(cnt)};
  endfunction

  // Reference: walk slots in order, stop at a zero count, expand each repeat.
  function automatic void build_exp();
    int cnt, op, ab, bb, as, bs;
    exp_q.delete();
    for (int s = 0; s < 16; s++) begin
      cnt = int'(prog_m[s][8:0]);
      if (cnt == 0) break;
      op = int'(prog_m[s][44:41]);
      ab = int'(prog_m[s][40:33]);
      bb = int'(prog_m[s][32:25]);
      as = int'(prog_m[s][24:17]);
      bs = int'(prog_m[s][16:9]);
      for (int k = 0; k < cnt; k++)
        exp_q.push_back({4'(op), 8'((ab + k * as) % 256), 8'((bb + k * bs) % 256)});
    end
  endfunction

  task automatic write_desc(input int slot, input logic [DESC_W-1:0] d, input bit model_it);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = 4'(slot); prog_wdata = d;
    @(negedge clk);
    prog_we = 1'b0;
    if (model_it) prog_m[slot] = d;
  endtask

  task automatic pulse_start();
    got_q.delete();
    done_cnt = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_abort();
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int cyc = 0;
    while (done_cnt == 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (done_cnt == 0) begin
      bad++;
      $display("FAIL %s timeout: no done after %0d cycles (issued_cnt=%0d)", name, budget, issued_cnt);
      pulse_abort();
    end
  endtask

  task automatic check_run(input string name);
    int errs = 0;
    build_exp();
    repeat (3) @(negedge clk);
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL %s count: got %0d instructions, expected %0d", name, got_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      total++;
      if (got_q[k] !== exp_q[k]) begin
        bad++;
        if (errs < 8)
          $display("FAIL %s instr[%0d]: got %h expected %h", name, k, got_q[k], exp_q[k]);
        errs++;
      end
    end
    total++;
    if (issued_cnt !== 16'(exp_q.size())) begin
      bad++;
      $display("FAIL %s issued_cnt: got %0d expected %0d", name, issued_cnt, exp_q.size());
    end
    total++;
    if (done_cnt != 1) begin
      bad++;
      $display("FAIL %s done pulses: got %0d expected 1", name, done_cnt);
    end
    total++;
    if (instruction !== IDLE_I || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s end state: instruction=%h busy=%b expected %h/0", name, instruction, busy, IDLE_I);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    total++;
    if (instruction !== IDLE_I || busy !== 1'b0 || done !== 1'b0 || issued_cnt !== 16'd0) begin
      bad++;
      $display("FAIL %s: instruction=%h busy=%b done=%b issued_cnt=%0d expected %h/0/0/0",
               name, instruction, busy, done, issued_cnt, IDLE_I);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("after_reset");
    // Reset mid-run behaves like power-on reset.
    write_desc(0, mk_desc(0, 7, 1, 2, 1, 1, 50), 1);
    write_desc(1, mk_desc(0, 0, 0, 0, 0, 0, 0), 1);
    pulse_start();
    repeat (15) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check_idle_outputs("reset_mid_run");
  endtask

  task automatic test_basic();
    flag_rand = 0;
    write_desc(0, mk_desc(0, 1, 0, 0, 1, 4, 64), 1);
    write_desc(1, mk_desc(0, 0, 0, 0, 0, 0, 0), 1);
    pulse_start();
    total++;
    if (busy !== 1'b1 || instruction !== IDLE_I) begin
      bad++;
      $display("FAIL basic_cycle1: busy=%b instruction=%h expected 1/%h", busy, instruction, IDLE_I);
    end
    @(negedge clk);
    total++;
    if (instruction !== 20'h1_00_00) begin
      bad++;
      $display("FAIL basic_latency: instruction=%h expected 10000", instruction);
    end
    wait_done("basic", 2000);
    check_run("basic");
  endtask

  task automatic test_wrap();
    flag_rand = 0;
    write_desc(0, mk_desc(0, 2, 250, 9, 4, 0, 3), 1);
    write_desc(1, mk_desc(0, 0, 0, 0, 0, 0, 0), 1);
    pulse_start();
    wait_done("wrap", 500);
    total++;
    if (got_q.size() != 3 || got_q[0][15:8] !== 8'd250 || got_q[1][15:8] !== 8'd254 ||
        got_q[2][15:8] !== 8'd2) begin
      bad++;
      $display("FAIL wrap_addra: got %0d entries, expected addra 250,254,2", got_q.size());
    end
    check_run("wrap");
  endtask

  task automatic test_sync();
    int cyc = 0;
    flag_rand = 0;
    idle_flag = 1'b1;
    write_desc(0, mk_desc(1, 2, 10, 20, 1, 2, 3), 1);
    write_desc(1, mk_desc(0, 0, 0, 0, 0, 0, 0), 1);
    pulse_start();
    while (issued_cnt !== 16'd1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    repeat (20) @(negedge clk);
    total++;
    if (issued_cnt !== 16'd1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL sync_hold: issued_cnt=%0d busy=%b expected 1/1", issued_cnt, busy);
    end
    idle_flag = 1'b0;
    wait_done("sync", 500);
    check_run("sync");
  endtask

  task automatic test_abort();
    int cyc = 0;
    int hi = 0;
    flag_rand = 0;
    write_desc(0, mk_desc(0, 3, 5, 6, 1, 1, 10), 1);
    write_desc(1, mk_desc(0, 0, 0, 0, 0, 0, 0), 1);
    pulse_start();
    while (hi < 2 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (issued_cnt === 16'd4 && flag === 1'b1) hi++;
      else hi = 0;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++;
    if (instruction !== IDLE_I || busy !== 1'b0 || issued_cnt !== 16'd4) begin
      bad++;
      $display("FAIL abort_next: instruction=%h busy=%b issued_cnt=%0d expected %h/0/4",
               instruction, busy, issued_cnt, IDLE_I);
    end
    repeat (10) @(negedge clk);
    total++;
    if (done_cnt != 0) begin
      bad++;
      $display("FAIL abort_no_done: got %0d done pulses expected 0", done_cnt);
    end
    write_desc(0, mk_desc(0, 6, 100, 200, 3, 5, 2), 1);
    pulse_start();
    wait_done("after_abort", 500);
    check_run("after_abort");
  endtask

  task automatic test_full_program();
    flag_rand = 0;
    for (int s = 0; s < 16; s++)
      write_desc(s, mk_desc(1'($urandom_range(0, 1)), int'($urandom_range(1, 15)),
                            int'($urandom), int'($urandom), int'($urandom), int'($urandom),
                            int'($urandom_range(1, 3))), 1);
    pulse_start();
    write_desc(0, mk_desc(0, 9, 1, 1, 1, 1, 7), 0);
    wait_done("full", 4000);
    check_run("full");
    pulse_start();
    wait_done("full_rerun", 4000);
    check_run("full_rerun");
  endtask

  task automatic test_random();
    int n;
    flag_rand = 1;
    for (int it = 0; it < 4; it++) begin
      n = int'($urandom_range(1, 6));
      for (int s = 0; s < n; s++)
        write_desc(s, mk_desc(1'($urandom_range(0, 1)), int'($urandom_range(1, 15)),
                              int'($urandom), int'($urandom), int'($urandom), int'($urandom),
                              int'($urandom_range(1, 6))), 1);
      write_desc(n, mk_desc(0, 0, 0, 0, 0, 0, 0), 1);
      pulse_start();
      wait_done("random", 3000);
      check_run("random");
    end
    flag_rand = 0;
  endtask

`ifdef SA_SEQ_STEP_EN
  task automatic test_step_mode();
    flag_rand = 0;
    step_mode = 1'b1;
    write_desc(0, mk_desc(0, 5, 0, 0, 1, 1, 5), 1);
    write_desc(1, mk_desc(0, 0, 0, 0, 0, 0, 0), 1);
    pulse_start();
    for (int k = 1; k <= 3; k++) begin
      repeat (6) @(negedge clk);
      total++;
      if (issued_cnt !== 16'(k - 1)) begin
        bad++;
        $display("FAIL step_stall[%0d]: issued_cnt=%0d expected %0d", k, issued_cnt, k - 1);
      end
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      repeat (20) @(negedge clk);
      total++;
      if (issued_cnt !== 16'(k)) begin
        bad++;
        $display("FAIL step_count[%0d]: issued_cnt=%0d expected %0d", k, issued_cnt, k);
      end
    end
    step_mode = 1'b0;
    wait_done("step", 500);
    check_run("step");
  endtask
`endif

  initial begin
    reset_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
    start = 1'b0; abort = 1'b0; idle_flag = 1'b0;
`ifdef SA_SEQ_STEP_EN
    step_mode = 1'b0; step = 1'b0;
`endif
    for (int s = 0; s < 16; s++) prog_m[s] = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_sync();
    test_abort();
    test_full_program();
    test_random();
`ifdef SA_SEQ_STEP_EN
    test_step_mode();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
